vscpu_core: RTL and testbench
=============================

# vscpu_core

Parametrised multi-cycle accumulator-less CPU core implementing the full eight-opcode memory-to-memory ISA. Each opcode has a direct mode and an immediate/indirect mode selected by an I bit. It sits between the program/data RAM (single port, one-cycle synchronous read) and the top-level testbench. Data width, address width, run/stall control and self-loop halt detection are generalised over the previous single-width core.

## Interface
- DATA_W, 16, data and instruction word width; even, ≥12
- ADDR_W, 10, RAM address and PC width; must be ≥ F = (DATA_W-4)/2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  when 0 the core holds in FETCH and starts no new instruction
- data_fromRAM  in  DATA_W  RAM read data, valid one cycle after its address was driven
- wrEn  out  1  RAM write enable; addr_toRAM/data_toRAM sampled by RAM on the same edge
- addr_toRAM  out  ADDR_W  RAM address
- data_toRAM  out  DATA_W  RAM write data; 0 whenever wrEn=0
- pCounter  out  ADDR_W  program counter (registered)
- halted  out  1  registered; 1 after a branch-to-self, sticky until rst
- instr_done  out  1  one-cycle pulse in the EXEC cycle of every instruction

## Operation
- Instruction layout: opcode=IR[DATA_W-1:DATA_W-3], I=IR[DATA_W-4], A=IR[2F-1:F], B=IR[F-1:0]. A and B are zero-extended to ADDR_W as addresses and to DATA_W as immediates.
- Semantics: *X = mem[X]. All results are truncated to DATA_W.
  - 000 ADD: *A=*A+*B; ADDi: *A=*A+B
  - 001 NAND: *A=~(*A&*B); NANDi: *A=~(*A&B)
  - 010 SRL: s=*B (SRLi: s=B). If s<DATA_W, *A=*A>>s; else *A=*A<<(s-DATA_W). Shifts ≥DATA_W in either direction yield 0.
  - 011 LT: *A=(*A<*B)?1:0, unsigned; LTi compares with B
  - 100 CP: *A=*B; CPi: *A=B
  - 101 CPI: *A=mem[*B]; CPIi: mem[*A]=*B
  - 110 BZJ: pc=(*B==0)?*A:pc+1; BZJi: pc=*A+B
  - 111 MUL: *A=low DATA_W bits of *A×*B; MULi uses B
- Branch targets take the low ADDR_W bits. Non-branch instructions set pc=pc+1, wrapping mod 2^ADDR_W.
- Halt: a taken BZJ or any BZJi whose target equals the current pc sets halted=1. pc is unchanged and the FSM enters HALT, where it stays with wrEn=0, addr_toRAM=pc, until rst.
- FSM states:
  - FETCH: addr=pc; go to DECODE if run, else stay
  - DECODE: IR←data; addr=A; go to RDA
  - RDA: opA←data. If the instruction needs *B (all I=0 except none; plus CPIi), addr=B and go to RDB; else go to EXEC
  - RDB: opB←data. For CPI (I=0), addr=data[ADDR_W-1:0] and go to RDIND; else go to EXEC
  - RDIND: opB←data; go to EXEC
  - EXEC: drive the write (addr=A; CPIi: addr=opA) with wrEn=1, or update pc for branches (wrEn=0). Pulse instr_done. Go to FETCH, or HALT on self-branch.
- Outputs addr_toRAM, wrEn and data_toRAM are combinational from state; defaults are 0 outside the listed cases.

## Timing
- Reset: state=FETCH, pc=0, IR/opA/opB=0, halted=0. wrEn=0, data_toRAM=0 and addr_toRAM=0 during any cycle with rst=1.
- rst asserted mid-instruction aborts the instruction with no write. Fetch from address 0 starts on the first cycle after rst deasserts.
- Latency per instruction (FETCH→EXEC inclusive):
  - 4 cycles: immediate ops ADDi, NANDi, SRLi, LTi, CPi, MULi, BZJi
  - 5 cycles: direct ops and CPIi
  - 6 cycles: CPI
- run is sampled only in FETCH. Deasserting run mid-instruction does not stall that instruction.
- Self-modifying code is legal. A write in EXEC is visible to the next FETCH, because the RAM write edge precedes the read.
- Operand address equal to own instruction address is legal; the value read is the value before the write.

## Test plan
- mem[0]=ADD A=10,B=11; mem[10]=7, mem[11]=9 → after 5 cycles mem[10]=16, pc=1, one instr_done pulse.
- SRLi A=10, B=3 with mem[10]=0x00F0 → 0x001E. SRLi B=20 → 0x0F00. SRL with *B=40 → 0.
- CPI A=10, B=11; mem[11]=12, mem[12]=0xBEEF → mem[10]=0xBEEF in 6 cycles. CPIi A=10, B=11; mem[10]=13, mem[11]=5 → mem[13]=5.
- BZJ with *B=0, *A=20 → pc=20. BZJ with *B=1 → pc+1. BZJi at pc=30 with *A=25, B=5 → halted=1; wrEn stays 0 for 100 cycles.
- MULi with *A=0x8001, B=2 → 0x0002. LT with *A=0xFFFF, *B=1 → 0. pc=1023 executing CPi → pc=0.
- run=0 from reset → pc=0, no DECODE for 20 cycles. rst in RDB of an ADD → no write; the next fetch is at address 0.

Source files
------------

// File: rtl/vscpu_core.sv
// ---------------------------------------------------------------------------
// vscpu_core
// Multi-cycle memory-to-memory CPU core with an eight-opcode ISA. Every
// opcode has a direct form (I=0, operands read through memory) and an
// immediate/indirect form (I=1). The core talks to a single-port RAM with
// a one-cycle synchronous read.
//
// Parameters:
//   DATA_W  data / instruction word width (even, >= 12)
//   ADDR_W  RAM address and PC width (>= (DATA_W-4)/2)
//
// Ports:
//   clk           clock, all state updates on rising edge
//   rst           synchronous active-high reset
//   run           0 holds the core in FETCH (sampled only in FETCH)
//   data_fromRAM  RAM read data, valid one cycle after its address
//   wrEn          RAM write enable
//   addr_toRAM    RAM address
//   data_toRAM    RAM write data, 0 whenever wrEn = 0
//   pCounter      registered program counter
//   halted        sticky flag set by a branch-to-self
//   instr_done    one-cycle pulse in the EXEC cycle of every instruction
// ---------------------------------------------------------------------------
module vscpu_core #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [DATA_W-1:0] data_fromRAM,
   output logic              wrEn,
   output logic [ADDR_W-1:0] addr_toRAM,
   output logic [DATA_W-1:0] data_toRAM,
   output logic [ADDR_W-1:0] pCounter,
   output logic              halted,
   output logic              instr_done
);

   // Operand field width: A and B each take F bits below the opcode and I bit.
   localparam int F = (DATA_W - 4) / 2;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_RDA    = 3'd2;
   localparam logic [2:0] S_RDB    = 3'd3;
   localparam logic [2:0] S_RDIND  = 3'd4;
   localparam logic [2:0] S_EXEC   = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_NAND = 3'b001;
   localparam logic [2:0] OP_SRL  = 3'b010;
   localparam logic [2:0] OP_LT   = 3'b011;
   localparam logic [2:0] OP_CP   = 3'b100;
   localparam logic [2:0] OP_CPI  = 3'b101;
   localparam logic [2:0] OP_BZJ  = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;

   localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W[DATA_W-1:0];

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic              halted_q, halted_d;

   // Instruction fields, taken from the latched IR.
   logic [2:0]   opcode;
   logic         i_bit;
   logic [F-1:0] a_fld;
   logic [F-1:0] b_fld;

   assign opcode = ir_q[DATA_W-1:DATA_W-3];
   assign i_bit  = ir_q[DATA_W-4];
   assign a_fld  = ir_q[2*F-1:F];
   assign b_fld  = ir_q[F-1:0];

   // Second ALU operand: the immediate B for I=1, otherwise the fetched *B.
   logic [DATA_W-1:0] b_op;
   assign b_op = i_bit ? DATA_W'(b_fld) : opb_q;

   // Every direct opcode reads *B; of the I=1 forms only CPIi does.
   logic needs_b;
   assign needs_b = !i_bit || (opcode == OP_CPI);

   logic [DATA_W-1:0] result;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] pc_inc;

   assign pc_inc = pc_q + ADDR_W'(1);

   // NOTE: every signal written in a combinational block gets a default at
   // the top so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      result = '0;
      case (opcode)
         OP_ADD:  result = opa_q + b_op;
         OP_NAND: result = ~(opa_q & b_op);
         // Shift amounts past the word width naturally shift everything out.
         OP_SRL:  result = (b_op < SHIFT_LIM) ? (opa_q >> b_op)
                                               : (opa_q << (b_op - SHIFT_LIM));
         OP_LT:   result = {{(DATA_W-1){1'b0}}, (opa_q < b_op)};
         OP_CP:   result = b_op;
         // CPI: opB holds mem[*B]; CPIi: opB holds *B, written to mem[*A].
         OP_CPI:  result = opb_q;
         OP_MUL:  result = opa_q * b_op;
         default: result = '0;
      endcase
   end

   always_comb begin
      if (i_bit)
         branch_target = ADDR_W'(opa_q + DATA_W'(b_fld));
      else if (opb_q == '0)
         branch_target = ADDR_W'(opa_q);
      else
         branch_target = pc_inc;
   end

   // Next-state logic and RAM bus drive.
   logic              wr_en_c;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] wdata_c;
   logic              done_c;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      halted_d = halted_q;
      wr_en_c  = 1'b0;
      addr_c   = '0;
      wdata_c  = '0;
      done_c   = 1'b0;

      case (state_q)
         S_FETCH: begin
            addr_c = pc_q;
            if (run) state_d = S_DECODE;
         end
         S_DECODE: begin
            // IR is not latched yet, so the A address comes straight off the bus.
            ir_d    = data_fromRAM;
            addr_c  = ADDR_W'(data_fromRAM[2*F-1:F]);
            state_d = S_RDA;
         end
         S_RDA: begin
            opa_d = data_fromRAM;
            if (needs_b) begin
               addr_c  = ADDR_W'(b_fld);
               state_d = S_RDB;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_RDB: begin
            opb_d = data_fromRAM;
            if (opcode == OP_CPI && !i_bit) begin
               addr_c  = ADDR_W'(data_fromRAM);
               state_d = S_RDIND;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_RDIND: begin
            opb_d   = data_fromRAM;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            done_c  = 1'b1;
            state_d = S_FETCH;
            if (opcode == OP_BZJ) begin
               pc_d = branch_target;
               // A not-taken BZJ yields pc+1, which never equals pc.
               if (branch_target == pc_q) begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
            end else begin
               wr_en_c = 1'b1;
               addr_c  = (opcode == OP_CPI && i_bit) ? ADDR_W'(opa_q)
                                                      : ADDR_W'(a_fld);
               wdata_c = result;
               pc_d    = pc_inc;
            end
         end
         S_HALT: begin
            addr_c = pc_q;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Bus outputs are forced idle while rst is high so an aborted EXEC
   // cannot write.
   assign wrEn       = wr_en_c & ~rst;
   assign addr_toRAM = rst ? '0 : addr_c;
   assign data_toRAM = (wr_en_c & ~rst) ? wdata_c : '0;
   assign instr_done = done_c & ~rst;
   assign pCounter   = pc_q;
   assign halted     = halted_q;

   // NOTE: sequential state is updated with non-blocking assignments only,
   // so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         halted_q <= halted_d;
      end
   end

endmodule

// File: tb/tb_vscpu_core.sv
// ---------------------------------------------------------------------------
// tb_vscpu_core
// Directed bench for vscpu_core: a behavioural single-port RAM with a
// one-cycle read, short hand-assembled programs, and hand-computed results.
// ---------------------------------------------------------------------------
module tb_vscpu_core;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 10;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_NAND = 3'b001;
   localparam logic [2:0] OP_SRL  = 3'b010;
   localparam logic [2:0] OP_LT   = 3'b011;
   localparam logic [2:0] OP_CP   = 3'b100;
   localparam logic [2:0] OP_CPI  = 3'b101;
   localparam logic [2:0] OP_BZJ  = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;

   logic              clk = 1'b0;
   logic              rst;
   logic              run;
   logic [DATA_W-1:0] data_fromRAM;
   logic              wrEn;
   logic [ADDR_W-1:0] addr_toRAM;
   logic [DATA_W-1:0] data_toRAM;
   logic [ADDR_W-1:0] pCounter;
   logic              halted;
   logic              instr_done;

   int n_checks = 0;
   int n_errors = 0;

   int done_cnt    = 0;
   int wr_cnt      = 0;
   int nz_addr_cnt = 0;
   int data_viol   = 0;

   logic [DATA_W-1:0] mem [1 << ADDR_W];

   always #5 clk = ~clk;

   vscpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .data_fromRAM (data_fromRAM),
      .wrEn         (wrEn),
      .addr_toRAM   (addr_toRAM),
      .data_toRAM   (data_toRAM),
      .pCounter     (pCounter),
      .halted       (halted),
      .instr_done   (instr_done)
   );

   // RAM: the read captures the pre-write contents of the addressed word.
   always @(posedge clk) begin
      data_fromRAM <= mem[addr_toRAM];
      if (wrEn) mem[addr_toRAM] = data_toRAM;
   end

   // Bus activity counters, sampled on the rising edge.
   always @(posedge clk) begin
      if (instr_done) done_cnt++;
      if (wrEn) wr_cnt++;
      if (addr_toRAM != '0) nz_addr_cnt++;
      if (!wrEn && data_toRAM != '0) data_viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] enc(input logic [2:0] op, input logic i,
                                            input int a, input int b);
      logic [5:0] af;
      logic [5:0] bf;
      af = a[5:0];
      bf = b[5:0];
      return {op, i, af, bf};
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold reset for a cycle and clear the RAM; ends on a negedge with rst=1.
   task automatic begin_test();
      @(negedge clk);
      rst = 1'b1;
      run = 1'b1;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
      @(negedge clk);
   endtask

   task automatic go();
      rst         = 1'b0;
      done_cnt    = 0;
      wr_cnt      = 0;
      nz_addr_cnt = 0;
   endtask

   initial begin
      rst = 1'b1;
      run = 1'b1;

      // Reset state
      begin_test();
      check("rst_wren", 32'(wrEn), 32'd0);
      check("rst_addr", 32'(addr_toRAM), 32'd0);
      check("rst_data", 32'(data_toRAM), 32'd0);
      check("rst_pc", 32'(pCounter), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_done", 32'(instr_done), 32'd0);

      // ADD direct: 7 + 9, five cycles
      mem[0] = enc(OP_ADD, 1'b0, 10, 11); mem[10] = 16'd7; mem[11] = 16'd9;
      go();
      cycles(4);
      check("add_not_yet", 32'(mem[10]), 32'd7);
      cycles(1);
      check("add_result", 32'(mem[10]), 32'd16);
      check("add_pc", 32'(pCounter), 32'd1);
      check("add_done_cnt", 32'(done_cnt), 32'd1);

      // Immediate and direct ALU ops: {opcode, I, *A, B-field, *B, cycles, expected}
      begin
         logic [2:0]  op_t  [9] = '{OP_SRL, OP_SRL, OP_SRL, OP_MUL, OP_LT, OP_LT,
                                    OP_NAND, OP_ADD, OP_CP};
         logic        i_t   [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
         logic [15:0] a_t   [9] = '{16'h00F0, 16'h00F0, 16'h00F0, 16'h8001, 16'hFFFF,
                                    16'h0003, 16'hFF0F, 16'hFFFF, 16'h5555};
         int          bf_t  [9] = '{3, 20, 11, 2, 11, 5, 63, 1, 11};
         logic [15:0] b_t   [9] = '{16'h0, 16'h0, 16'd40, 16'h0, 16'h0001, 16'h0,
                                    16'h0, 16'h0, 16'h1234};
         int          cyc_t [9] = '{4, 4, 5, 4, 5, 4, 4, 4, 5};
         logic [15:0] exp_t [9] = '{16'h001E, 16'h0F00, 16'h0000, 16'h0002, 16'h0000,
                                    16'h0001, 16'hFFF0, 16'h0000, 16'h1234};
         string       tag_t [9] = '{"srli_3", "srli_20", "srl_40", "muli_wrap", "lt_unsigned",
                                    "lti_true", "nandi", "addi_wrap", "cp_direct"};
         for (int k = 0; k < 9; k++) begin
            begin_test();
            mem[0]  = enc(op_t[k], i_t[k], 10, bf_t[k]);
            mem[10] = a_t[k];
            mem[11] = b_t[k];
            go();
            cycles(cyc_t[k]);
            check(tag_t[k], 32'(mem[10]), 32'(exp_t[k]));
            check({tag_t[k], "_pc"}, 32'(pCounter), 32'd1);
         end
      end

      // CPI direct: mem[10] = mem[mem[11]], six cycles
      begin_test();
      mem[0] = enc(OP_CPI, 1'b0, 10, 11); mem[11] = 16'd12; mem[12] = 16'hBEEF;
      go();
      cycles(5);
      check("cpi_not_yet", 32'(mem[10]), 32'd0);
      cycles(1);
      check("cpi_result", 32'(mem[10]), 32'hBEEF);

      // CPIi: mem[mem[10]] = mem[11], five cycles
      begin_test();
      mem[0] = enc(OP_CPI, 1'b1, 10, 11); mem[10] = 16'd13; mem[11] = 16'd5;
      go();
      cycles(5);
      check("cpii_result", 32'(mem[13]), 32'd5);
      check("cpii_a_kept", 32'(mem[10]), 32'd13);

      // BZJ taken and not taken
      begin_test();
      mem[0] = enc(OP_BZJ, 1'b0, 10, 11); mem[10] = 16'd20; mem[11] = 16'd0;
      go();
      cycles(5);
      check("bzj_taken_pc", 32'(pCounter), 32'd20);
      check("bzj_no_write", 32'(wr_cnt), 32'd0);
      check("bzj_not_halted", 32'(halted), 32'd0);

      begin_test();
      mem[0] = enc(OP_BZJ, 1'b0, 10, 11); mem[10] = 16'd20; mem[11] = 16'd1;
      go();
      cycles(5);
      check("bzj_fall_pc", 32'(pCounter), 32'd1);

      // BZJi to 30, then BZJi at 30 with *A=25, B=5: branch to self
      begin_test();
      mem[0]  = enc(OP_BZJ, 1'b1, 10, 30); mem[10] = 16'd0;
      mem[30] = enc(OP_BZJ, 1'b1, 11, 5);  mem[11] = 16'd25;
      go();
      cycles(4);
      check("bzji_jump_pc", 32'(pCounter), 32'd30);
      check("bzji_jump_halted", 32'(halted), 32'd0);
      cycles(4);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_pc", 32'(pCounter), 32'd30);
      check("halt_done_cnt", 32'(done_cnt), 32'd2);
      wr_cnt   = 0;
      done_cnt = 0;
      cycles(100);
      check("halt_no_write", 32'(wr_cnt), 32'd0);
      check("halt_no_done", 32'(done_cnt), 32'd0);
      check("halt_sticky", 32'(halted), 32'd1);
      check("halt_addr", 32'(addr_toRAM), 32'd30);
      begin_test();
      check("halt_cleared_by_rst", 32'(halted), 32'd0);
      check("halt_pc_cleared", 32'(pCounter), 32'd0);

      // PC wrap: jump to 1023, execute CPi there
      mem[0]    = enc(OP_BZJ, 1'b0, 10, 11); mem[10] = 16'd1023; mem[11] = 16'd0;
      mem[1023] = enc(OP_CP, 1'b1, 12, 7);
      go();
      cycles(5);
      check("wrap_pc_1023", 32'(pCounter), 32'd1023);
      cycles(4);
      check("wrap_cpi_result", 32'(mem[12]), 32'd7);
      check("wrap_pc_0", 32'(pCounter), 32'd0);

      // run=0 from reset: stays in FETCH at address 0
      begin_test();
      mem[0] = enc(OP_ADD, 1'b0, 10, 11); mem[10] = 16'd7; mem[11] = 16'd9;
      run = 1'b0;
      go();
      cycles(20);
      check("stall_pc", 32'(pCounter), 32'd0);
      check("stall_no_decode", 32'(nz_addr_cnt), 32'd0);
      check("stall_no_done", 32'(done_cnt), 32'd0);
      run = 1'b1;
      cycles(5);
      check("stall_release_result", 32'(mem[10]), 32'd16);

      // rst asserted in RDB of an ADD aborts without a write
      begin_test();
      mem[0] = enc(OP_ADD, 1'b0, 10, 11); mem[10] = 16'd7; mem[11] = 16'd9;
      go();
      cycles(3);
      rst    = 1'b1;
      wr_cnt = 0;
      cycles(2);
      check("abort_no_write", 32'(wr_cnt), 32'd0);
      check("abort_mem_kept", 32'(mem[10]), 32'd7);
      go();
      check("abort_refetch_addr", 32'(addr_toRAM), 32'd0);
      cycles(5);
      check("abort_rerun_result", 32'(mem[10]), 32'd16);
      check("abort_rerun_pc", 32'(pCounter), 32'd1);

      check("data_zero_when_idle", 32'(data_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
